// File: rtl/mac_pkg.sv
// Shared configuration, derived widths, saturation constants and the S1 stage
// register layout for the multi-lane MAC engine.
package mac_pkg;

    localparam int LANES_DEF    = 4;
    localparam int INT_IN_DEF   = 1;
    localparam int FRAC_IN_DEF  = 11;
    localparam int INT_OUT_DEF  = 10;
    localparam int FRAC_OUT_DEF = 22;

    localparam int in_w   = INT_IN_DEF + FRAC_IN_DEF;
    localparam int prod_w = 2 * in_w;
    localparam int acc_w  = INT_OUT_DEF + FRAC_OUT_DEF;

    // S1 holds the full-precision lane products plus the end-of-vector marker.
    typedef struct packed {
        logic [LANES_DEF-1:0][prod_w-1:0] prod;
        logic                             last;
    } s1_t;

    function automatic logic signed [acc_w-1:0] sat_max();
        return {1'b0, {(acc_w-1){1'b1}}};
    endfunction

    function automatic logic signed [acc_w-1:0] sat_min();
        return {1'b1, {(acc_w-1){1'b0}}};
    endfunction

endpackage

// File: rtl/mac_vec_adder_tree.sv
// Combinational signed reduction of the S1 lane products, sign-extended to the
// accumulator width plus one guard bit.
module mac_vec_adder_tree
    import mac_pkg::*;
#(
    parameter int lanes_p  = LANES_DEF,
    parameter int prod_w_p = prod_w,
    parameter int sum_w_p  = acc_w + 1
) (
    input  logic [lanes_p-1:0][prod_w_p-1:0] i_prod,
    output logic signed [sum_w_p-1:0]        o_sum
);

    always_comb begin
        o_sum = '0;
        for (int i = 0; i < lanes_p; i++) begin
            o_sum = o_sum + $signed({{(sum_w_p-prod_w_p){i_prod[i][prod_w_p-1]}}, i_prod[i]});
        end
    end

endmodule

// File: rtl/mac_vec.sv
// Multi-lane fixed-point dot-product engine: S1 registers lane products, S2
// accumulates and emits one saturated/wrapped result per vector.
module mac_vec
    import mac_pkg::*;
#(
    parameter int lanes_p    = LANES_DEF,
    parameter int int_in_p   = INT_IN_DEF,
    parameter int frac_in_p  = FRAC_IN_DEF,
    parameter int int_out_p  = INT_OUT_DEF,
    parameter int frac_out_p = FRAC_OUT_DEF,
    parameter bit saturate_p = 1'b1
) (
    input  logic                                       clk_i,
    input  logic                                       reset_ni,
    input  logic [lanes_p*(int_in_p+frac_in_p)-1:0]    a_i,
    input  logic [lanes_p*(int_in_p+frac_in_p)-1:0]    b_i,
    input  logic                                       last_i,
    input  logic                                       valid_i,
    output logic                                       ready_o,
    output logic signed [int_out_p+frac_out_p-1:0]     data_o,
    output logic                                       overflow_o,
    output logic                                       valid_o,
    input  logic                                       ready_i
);

    localparam int IN_W = int_in_p + frac_in_p;
    localparam int PW   = 2 * IN_W;
    localparam int AW   = int_out_p + frac_out_p;

    logic                          w_adv;
    logic [lanes_p-1:0][PW-1:0]    w_prod;
    s1_t                           r_s1_p1;
    logic                          r_vld_p1;
    logic signed [AW:0]            w_sum;
    logic signed [AW:0]            w_next;
    logic                          w_ovf;
    logic signed [AW-1:0]          w_res;
    logic signed [AW-1:0]          r_acc_p2;
    logic                          r_sticky_p2;
    logic signed [AW-1:0]          r_data_p2;
    logic                          r_ovf_p2;
    logic                          r_vld_p2;

    function automatic logic [PW-1:0] mul_lane(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] bx;
        ax = {{IN_W{a[IN_W-1]}}, a};
        bx = {{IN_W{b[IN_W-1]}}, b};
        return ax * bx;
    endfunction

    function automatic logic signed [AW-1:0] sat_wrap(input logic signed [AW:0] v);
        if (saturate_p && (v[AW] != v[AW-1])) begin
            return v[AW] ? sat_min() : sat_max();
        end
        return v[AW-1:0];
    endfunction

    assign w_adv   = !r_vld_p2 || ready_i;
    assign ready_o = w_adv;

    always_comb begin
        w_prod = '0;
        for (int i = 0; i < lanes_p; i++) begin
            w_prod[i] = mul_lane(a_i[i*IN_W +: IN_W], b_i[i*IN_W +: IN_W]);
        end
    end

    // ---- S1: lane products ----
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_vld_p1 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1 <= valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_adv && valid_i) begin
            r_s1_p1.prod <= w_prod;
            r_s1_p1.last <= last_i;
        end
    end

    mac_vec_adder_tree #(
        .lanes_p  (lanes_p),
        .prod_w_p (PW),
        .sum_w_p  (AW + 1)
    ) u_tree (
        .i_prod (r_s1_p1.prod),
        .o_sum  (w_sum)
    );

    // ---- S2: accumulate, clamp/wrap, output register ----
    assign w_next = {r_acc_p2[AW-1], r_acc_p2} + w_sum;
    assign w_ovf  = w_next[AW] ^ w_next[AW-1];
    // A clamped accumulator is frozen until the vector closes.
    assign w_res  = (saturate_p && r_sticky_p2) ? r_acc_p2 : sat_wrap(w_next);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_acc_p2    <= '0;
            r_sticky_p2 <= 1'b0;
            r_data_p2   <= '0;
            r_ovf_p2    <= 1'b0;
            r_vld_p2    <= 1'b0;
        end else if (w_adv) begin
            r_vld_p2 <= r_vld_p1 && r_s1_p1.last;
            if (r_vld_p1) begin
                if (r_s1_p1.last) begin
                    r_data_p2   <= w_res;
                    r_ovf_p2    <= w_ovf || r_sticky_p2;
                    r_acc_p2    <= '0;
                    r_sticky_p2 <= 1'b0;
                end else begin
                    r_acc_p2    <= w_res;
                    r_sticky_p2 <= r_sticky_p2 || w_ovf;
                end
            end
        end
    end

    assign data_o     = r_data_p2;
    assign overflow_o = r_ovf_p2;
    assign valid_o    = r_vld_p2;

endmodule

// File: tb/tb_mac_vec.sv
// Directed bench for mac_vec: a saturating and a wrapping instance share stimulus.
module tb_mac_vec;

    logic        clk;
    logic        reset_n;
    logic [47:0] a;
    logic [47:0] b;
    logic        last;
    logic        valid;
    logic        ready_i;
    logic        ready_s, ready_w;
    logic [31:0] data_s, data_w;
    logic        ovf_s, ovf_w;
    logic        valid_s, valid_w;

    int n_chk = 0;
    int n_err = 0;

    logic [32:0] q_s[$];
    logic [32:0] q_w[$];

    mac_vec #(.saturate_p(1'b1)) u_dut (
        .clk_i(clk), .reset_ni(reset_n), .a_i(a), .b_i(b), .last_i(last),
        .valid_i(valid), .ready_o(ready_s), .data_o(data_s), .overflow_o(ovf_s),
        .valid_o(valid_s), .ready_i(ready_i)
    );

    mac_vec #(.saturate_p(1'b0)) u_dut_w (
        .clk_i(clk), .reset_ni(reset_n), .a_i(a), .b_i(b), .last_i(last),
        .valid_i(valid), .ready_o(ready_w), .data_o(data_w), .overflow_o(ovf_w),
        .valid_o(valid_w), .ready_i(ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results are collected where the handshake is stable for the coming edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (valid_s && ready_i) q_s.push_back({ovf_s, data_s});
            if (valid_w && ready_i) q_w.push_back({ovf_w, data_w});
        end
    end

    function automatic logic [47:0] pk(input logic [11:0] l0, input logic [11:0] l1,
                                       input logic [11:0] l2, input logic [11:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [47:0] av, input logic [47:0] bv, input logic lst);
        int t;
        t     = 0;
        a     = av;
        b     = bv;
        last  = lst;
        valid = 1'b1;
        @(negedge clk);
        while (!ready_s && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("accept_timeout", 64'(ready_s), 64'(1'b1));
        @(posedge clk);
        #1;
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int n);
        int t;
        t = 0;
        while ((q_s.size() < n || q_w.size() < n) && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_cnt_sat"}, 64'(q_s.size()), 64'(n));
        chk({tag, "_cnt_wrap"}, 64'(q_w.size()), 64'(n));
    endtask

    task automatic get_res(input string tag, input logic [32:0] exp_s, input logic [32:0] exp_w);
        logic [32:0] gs;
        logic [32:0] gw;
        gs = 'x;
        gw = 'x;
        if (q_s.size() > 0) gs = q_s.pop_front();
        if (q_w.size() > 0) gw = q_w.pop_front();
        chk({tag, "_sat"}, 64'(gs), 64'(exp_s));
        chk({tag, "_wrap"}, 64'(gw), 64'(exp_w));
    endtask

    task automatic clear_q();
        q_s.delete();
        q_w.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        ready_i = 1'b1;
        valid   = 1'b0;
        last    = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(valid_s), 64'(1'b0));
        chk("rst_ovf", 64'(ovf_s), 64'(1'b0));
        chk("rst_ready", 64'(ready_s), 64'(1'b1));
        chk("rst_data", 64'(data_s), 64'(32'h0));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, all lanes 0.5*0.5 -> 1.0, check two-edge latency
        clear_q();
        send(pk(12'h400, 12'h400, 12'h400, 12'h400), pk(12'h400, 12'h400, 12'h400, 12'h400), 1'b1);
        chk("t1_valid_early", 64'(valid_s), 64'(1'b0));
        @(posedge clk);
        #1;
        chk("t1_valid", 64'(valid_s), 64'(1'b1));
        chk("t1_data", 64'(data_s), 64'(32'h0040_0000));
        chk("t1_ovf", 64'(ovf_s), 64'(1'b0));
        wait_res("t1", 1);
        get_res("t1_res", {1'b0, 32'h0040_0000}, {1'b0, 32'h0040_0000});

        // Three beats lane0 0.25 each -> 0.75
        clear_q();
        send(pk(12'h400, 0, 0, 0), pk(12'h400, 0, 0, 0), 1'b0);
        chk("t2_valid_b1", 64'(valid_s), 64'(1'b0));
        send(pk(12'h400, 0, 0, 0), pk(12'h400, 0, 0, 0), 1'b0);
        chk("t2_valid_b2", 64'(valid_s), 64'(1'b0));
        send(pk(12'h400, 0, 0, 0), pk(12'h400, 0, 0, 0), 1'b1);
        wait_res("t2", 1);
        get_res("t2_res", {1'b0, 32'h0030_0000}, {1'b0, 32'h0030_0000});

        // Back-to-back vectors with consumer stall
        clear_q();
        ready_i = 1'b0;
        send(pk(12'h400, 12'h400, 12'h400, 12'h400), pk(12'h400, 12'h400, 12'h400, 12'h400), 1'b1);
        send(pk(12'h800, 0, 0, 0), pk(12'h400, 0, 0, 0), 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_valid", 64'(valid_s), 64'(1'b1));
            chk("t3_hold_data", 64'(data_s), 64'(32'h0040_0000));
            chk("t3_hold_ready", 64'(ready_s), 64'(1'b0));
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        wait_res("t3", 2);
        get_res("t3_v1", {1'b0, 32'h0040_0000}, {1'b0, 32'h0040_0000});
        get_res("t3_v2", {1'b0, 32'hFFE0_0000}, {1'b0, 32'hFFE0_0000});

        // 600 beats of +4.0: saturate vs wrap, then a clean vector
        clear_q();
        for (int i = 0; i < 600; i++) begin
            send(pk(12'h800, 12'h800, 12'h800, 12'h800), pk(12'h800, 12'h800, 12'h800, 12'h800), (i == 599));
        end
        wait_res("t4", 1);
        get_res("t4_ovf", {1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h5800_0000});
        send(pk(12'h400, 0, 0, 0), pk(12'h400, 0, 0, 0), 1'b1);
        wait_res("t4b", 1);
        get_res("t4_after", {1'b0, 32'h0010_0000}, {1'b0, 32'h0010_0000});

        // Accumulator persists across an idle gap; lane1 contributes -0.5
        clear_q();
        send(pk(12'h400, 12'h400, 12'h400, 12'h400), pk(12'h400, 12'h400, 12'h400, 12'h400), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        send(pk(0, 12'h400, 0, 0), pk(0, 12'h800, 0, 0), 1'b1);
        wait_res("t5", 1);
        get_res("t5_gap", {1'b0, 32'h0020_0000}, {1'b0, 32'h0020_0000});

        // Mixed lanes: 0.125 - 0.75 + 0.25 = -0.375
        clear_q();
        send(pk(12'h200, 0, 12'h600, 12'hC00), pk(12'h400, 0, 12'h800, 12'hC00), 1'b1);
        wait_res("t6", 1);
        get_res("t6_mix", {1'b0, 32'hFFE8_0000}, {1'b0, 32'hFFE8_0000});

        // Reset mid-vector discards the partial sum
        clear_q();
        send(pk(12'h400, 0, 0, 0), pk(12'h400, 0, 0, 0), 1'b0);
        send(pk(12'h400, 0, 0, 0), pk(12'h400, 0, 0, 0), 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t7_rst_valid", 64'(valid_s), 64'(1'b0));
        chk("t7_rst_ovf", 64'(ovf_s), 64'(1'b0));
        chk("t7_rst_ready", 64'(ready_s), 64'(1'b1));
        chk("t7_rst_data", 64'(data_s), 64'(32'h0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(pk(12'h400, 0, 0, 0), pk(12'h400, 0, 0, 0), 1'b1);
        wait_res("t7", 1);
        get_res("t7_res", {1'b0, 32'h0010_0000}, {1'b0, 32'h0010_0000});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
